lc3b_sr_bank: RTL and testbench
===============================

# lc3b_sr_bank

Parametrised set/reset status-bit bank holding DEPTH entries of WIDTH independently set/clearable bits, for cache valid/dirty/LRU state in the pipelined LC-3b memory path. It adds per-bit set/clear masks, separate read and write indices, a multi-cycle flush sequencer with a busy/done handshake, and a live count of entries whose bit 0 is set.

## Interface
- WIDTH, 1, status bits per entry
- DEPTH, 8, number of entries; power of two, at least 2
- IDX_W, $clog2(DEPTH), derived index width; not overridden
- clk  input  1  clock; all state changes on its rising edge
- reset_n  input  1  asynchronous active-low reset
- wr_enable  input  1  apply set_mask/clr_mask to entry wr_index this edge
- wr_index  input  IDX_W  write entry select
- set_mask  input  WIDTH  bits to set in entry wr_index
- clr_mask  input  WIDTH  bits to clear in entry wr_index
- rd_index  input  IDX_W  read entry select
- rd_data  output  WIDTH  contents of entry rd_index
- flush_req  input  1  start a clear-all sweep; sampled in IDLE only
- flush_busy  output  1  sweep in progress
- flush_done  output  1  one-cycle pulse after the final entry is cleared
- set_count  output  IDX_W+1  number of entries with bit 0 set

## Operation
- Reset (reset_n low, takes effect immediately): all entries 0, FSM to IDLE, sweep pointer 0. Outputs during reset: rd_data 0, flush_busy 0, flush_done 0, set_count 0.
- Write: when wr_enable is high at a clock edge, entry wr_index takes (old & ~clr_mask) | set_mask. Set wins over clear on the same bit. Bits with both mask bits 0 are unchanged.
- Read: rd_data is combinational from the stored array. It shows pre-edge contents, with no write-to-read bypass. A write to the same index becomes visible the cycle after its edge.
- set_count: combinational popcount of bit 0 across all entries. It reaches DEPTH when every entry has bit 0 set.
- Flush FSM has two states, IDLE and SWEEP.
  - IDLE: flush_req high -> SWEEP with ptr = 0. Otherwise stay.
  - SWEEP: each edge clears all WIDTH bits of entry ptr, then increments ptr. When ptr == DEPTH-1, clear that entry, return to IDLE, reset ptr to 0 and assert flush_done on the following cycle.
  - flush_busy is high exactly while in SWEEP.
  - flush_req while in SWEEP is ignored; it is not queued.
- Write during SWEEP: writes are still accepted.
  - wr_index == ptr in the same cycle: the sweep clear overrides the write, including set_mask.
  - wr_index < ptr (already swept): the write persists.
  - wr_index > ptr: the write is cleared later by the sweep.
- Reset asserted mid-sweep: the sweep is abandoned, all entries are cleared and flush_done is not pulsed.

## Timing
- Write latency: 1 edge; visible on rd_data and set_count in the next cycle.
- Flush: flush_req sampled high at edge E0 makes flush_busy high from E0.
  - Entry k is cleared at edge E0+k+1.
  - flush_busy drops and flush_done rises after edge E0+DEPTH.
  - flush_done is high for exactly one cycle.
- Back-to-back flush: a flush_req high in the flush_done cycle starts a new sweep at that edge.
- Minimum spacing between sweeps is therefore DEPTH+1 cycles.
- No combinational path from any input to flush_busy or flush_done. rd_data and set_count are combinational from state only; rd_index is the one exception, feeding rd_data.

## Test plan
- Reset then read all indices: rd_data = 0 everywhere, set_count = 0. Assert reset_n low mid-run with entries set: outputs go to 0 without waiting for a clock edge.
- WIDTH=2, DEPTH=8: write idx 3 set_mask=2'b11 -> rd_data[3] = 2'b11 next cycle, set_count = 1. Then set=2'b01, clr=2'b11 -> 2'b01 (set wins on bit 0).
- Same-index read during write: rd_index = wr_index = 5, set_mask = 1 -> rd_data is 0 in the write cycle and 1 the cycle after.
- Fill all 8 entries' bit 0 -> set_count = 8. Pulse flush_req: flush_busy high for 8 cycles, set_count decrements by 1 per edge to 0, then one flush_done pulse. A second flush_req mid-sweep is ignored: total busy stays 8 cycles.
- During a sweep at ptr = 4:
  - set idx 4 in the same cycle -> stays 0.
  - set idx 2 -> persists.
  - set idx 6 -> cleared at its sweep edge.
- Drop reset_n at ptr = 3: all entries 0, flush_busy 0, no flush_done pulse. After release, a new flush_req runs a full DEPTH-cycle sweep.

Source files
------------

// File: rtl/lc3b_sr_bank.sv
// Status-bit bank for cache valid/dirty/LRU state: per-bit set/clear writes,
// combinational read, a bit-0 population count and a clear-all sweep sequencer.
module lc3b_sr_bank #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_enable,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WIDTH-1:0] set_mask,
  input  logic [WIDTH-1:0] clr_mask,
  input  logic [IDX_W-1:0] rd_index,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  output logic [IDX_W:0]   set_count,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W:0]   cnt;

  // Sequencer: flush_req is only looked at in IDLE, so requests during a
  // sweep are dropped rather than queued.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        if (ptr == IDX_W'(DEPTH - 1)) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      flush_done <= done_nxt;
    end
  end

  // The sweep clear on entry ptr takes priority over a same-cycle write there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state == SWEEP && ptr == IDX_W'(i)) begin
          mem[i] <= '0;
        end else if (wr_enable && wr_index == IDX_W'(i)) begin
          mem[i] <= (mem[i] & ~clr_mask) | set_mask;
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + (IDX_W + 1)'(mem[i][0]);
  end

  assign rd_data    = mem[rd_index];
  assign set_count  = cnt;
  assign flush_busy = (state == SWEEP);
  assign state_dbg  = state;

endmodule

// File: tb/tb_lc3b_sr_bank.sv
// Directed bench for lc3b_sr_bank (WIDTH=2, DEPTH=8): writes, read timing,
// sweep behaviour, writes racing the sweep, and asynchronous reset.
module tb_lc3b_sr_bank;
  localparam int WIDTH = 2;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_enable = 1'b0;
  logic [IDX_W-1:0] wr_index = '0;
  logic [WIDTH-1:0] set_mask = '0;
  logic [WIDTH-1:0] clr_mask = '0;
  logic [IDX_W-1:0] rd_index = '0;
  logic [WIDTH-1:0] rd_data;
  logic             flush_req = 1'b0;
  logic             flush_busy;
  logic             flush_done;
  logic [IDX_W:0]   set_count;
  logic             state_dbg;

  int checks = 0;
  int errors = 0;

  lc3b_sr_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_enable(wr_enable), .wr_index(wr_index),
    .set_mask(set_mask), .clr_mask(clr_mask), .rd_index(rd_index),
    .rd_data(rd_data), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .set_count(set_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] s,
                             input logic [WIDTH-1:0] c);
    wr_enable = 1'b1;
    wr_index  = idx;
    set_mask  = s;
    clr_mask  = c;
  endtask

  task automatic idle_write;
    wr_enable = 1'b0;
    set_mask  = '0;
    clr_mask  = '0;
  endtask

  // Counts busy cycles from just after the starting edge until flush_done, bounded.
  task automatic wait_sweep(output int busy_cycles, output logic got_done);
    busy_cycles = 0;
    for (int c = 0; c < 20 && !flush_done; c++) begin
      if (flush_busy) busy_cycles++;
      tick();
    end
    got_done = flush_done;
  endtask

  task automatic test_reset;
    for (int i = 0; i < DEPTH; i++) begin
      rd_index = IDX_W'(i);
      #1;
      checks++;
      if (rd_data !== 2'b00) begin
        errors++;
        $display("FAIL reset_rd idx %0d got %b exp 00", i, rd_data);
      end
    end
    checks++;
    if (set_count !== 4'd0 || flush_busy !== 1'b0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs cnt %0d busy %b done %b exp 0 0 0", set_count, flush_busy, flush_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write;
    rd_index = 3'd3;
    drive_write(3'd3, 2'b11, 2'b00);
    #1;
    checks++;
    if (rd_data !== 2'b00) begin
      errors++;
      $display("FAIL write_pre got %b exp 00", rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 2'b11 || set_count !== 4'd1) begin
      errors++;
      $display("FAIL write_set got %b cnt %0d exp 11 cnt 1", rd_data, set_count);
    end
    drive_write(3'd3, 2'b01, 2'b11);
    tick();
    checks++;
    if (rd_data !== 2'b01 || set_count !== 4'd1) begin
      errors++;
      $display("FAIL write_set_wins got %b cnt %0d exp 01 cnt 1", rd_data, set_count);
    end
    drive_write(3'd3, 2'b00, 2'b01);
    tick();
    checks++;
    if (rd_data !== 2'b00 || set_count !== 4'd0) begin
      errors++;
      $display("FAIL write_clr got %b cnt %0d exp 00 cnt 0", rd_data, set_count);
    end
    drive_write(3'd3, 2'b10, 2'b00);
    tick();
    drive_write(3'd3, 2'b00, 2'b00);
    tick();
    checks++;
    if (rd_data !== 2'b10 || set_count !== 4'd0) begin
      errors++;
      $display("FAIL write_hold got %b cnt %0d exp 10 cnt 0", rd_data, set_count);
    end
    idle_write();
  endtask

  task automatic test_same_index;
    rd_index = 3'd5;
    drive_write(3'd5, 2'b01, 2'b00);
    #1;
    checks++;
    if (rd_data !== 2'b00) begin
      errors++;
      $display("FAIL same_idx_now got %b exp 00", rd_data);
    end
    tick();
    idle_write();
    checks++;
    if (rd_data !== 2'b01) begin
      errors++;
      $display("FAIL same_idx_next got %b exp 01", rd_data);
    end
  endtask

  task automatic test_flush;
    int busy_cycles;
    for (int i = 0; i < DEPTH; i++) begin
      drive_write(IDX_W'(i), 2'b01, 2'b00);
      tick();
    end
    idle_write();
    checks++;
    if (set_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_count got %0d exp 8", set_count);
    end
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    checks++;
    if (flush_busy !== 1'b1 || flush_done !== 1'b0 || set_count !== 4'd8) begin
      errors++;
      $display("FAIL flush_start busy %b done %b cnt %0d exp 1 0 8", flush_busy, flush_done, set_count);
    end
    busy_cycles = 1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 3) flush_req = 1'b1;
      if (k == 4) flush_req = 1'b0;
      tick();
      checks++;
      if (set_count !== 4'(7 - k) || flush_busy !== (k < 7) || flush_done !== (k == 7)) begin
        errors++;
        $display("FAIL flush_step %0d cnt %0d busy %b done %b exp cnt %0d busy %b done %b",
                 k, set_count, flush_busy, flush_done, 7 - k, k < 7, k == 7);
      end
      if (flush_busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 8) begin
      errors++;
      $display("FAIL flush_busy_len got %0d exp 8", busy_cycles);
    end
    tick();
    checks++;
    if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_after done %b busy %b exp 0 0", flush_done, flush_busy);
    end
  endtask

  task automatic test_sweep_write;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    rd_index = 3'd6;
    drive_write(3'd6, 2'b11, 2'b00);
    tick();
    idle_write();
    checks++;
    if (rd_data !== 2'b11) begin
      errors++;
      $display("FAIL sweep_wr_ahead got %b exp 11", rd_data);
    end
    tick();
    tick();
    tick();
    rd_index = 3'd4;
    drive_write(3'd4, 2'b11, 2'b00);
    tick();
    checks++;
    if (rd_data !== 2'b00) begin
      errors++;
      $display("FAIL sweep_wr_at_ptr got %b exp 00", rd_data);
    end
    rd_index = 3'd2;
    drive_write(3'd2, 2'b11, 2'b00);
    tick();
    idle_write();
    checks++;
    if (rd_data !== 2'b11 || set_count !== 4'd2) begin
      errors++;
      $display("FAIL sweep_wr_behind got %b cnt %0d exp 11 cnt 2", rd_data, set_count);
    end
    rd_index = 3'd6;
    tick();
    checks++;
    if (rd_data !== 2'b00 || set_count !== 4'd1) begin
      errors++;
      $display("FAIL sweep_clears_ahead got %b cnt %0d exp 00 cnt 1", rd_data, set_count);
    end
    tick();
    rd_index = 3'd2;
    #1;
    checks++;
    if (flush_done !== 1'b1 || rd_data !== 2'b11) begin
      errors++;
      $display("FAIL sweep_end done %b rd2 %b exp 1 11", flush_done, rd_data);
    end
  endtask

  // Entered in the flush_done cycle left by test_sweep_write.
  task automatic test_back_to_back;
    int   busy_cycles;
    logic got_done;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    checks++;
    if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start busy %b done %b exp 1 0", flush_busy, flush_done);
    end
    wait_sweep(busy_cycles, got_done);
    checks++;
    if (busy_cycles != 8 || got_done !== 1'b1 || rd_data !== 2'b00 || set_count !== 4'd0) begin
      errors++;
      $display("FAIL b2b_sweep busy %0d done %b rd2 %b cnt %0d exp 8 1 00 0",
               busy_cycles, got_done, rd_data, set_count);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int   busy_cycles;
    logic got_done;
    logic saw_bad;
    drive_write(3'd0, 2'b01, 2'b00);
    tick();
    drive_write(3'd1, 2'b11, 2'b00);
    tick();
    drive_write(3'd5, 2'b01, 2'b00);
    tick();
    drive_write(3'd7, 2'b11, 2'b00);
    tick();
    idle_write();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    tick();
    rd_index = 3'd7;
    checks++;
    if (set_count !== 4'd2 || flush_busy !== 1'b1 || rd_data !== 2'b11) begin
      errors++;
      $display("FAIL mid_before cnt %0d busy %b rd7 %b exp 2 1 11", set_count, flush_busy, rd_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (set_count !== 4'd0 || flush_busy !== 1'b0 || flush_done !== 1'b0 || rd_data !== 2'b00) begin
      errors++;
      $display("FAIL mid_async cnt %0d busy %b done %b rd7 %b exp 0 0 0 00",
               set_count, flush_busy, flush_done, rd_data);
    end
    tick();
    tick();
    reset_n = 1'b1;
    saw_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (flush_done !== 1'b0 || flush_busy !== 1'b0) saw_bad = 1'b1;
    end
    checks++;
    if (saw_bad !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done got stray busy/done %b exp 0", saw_bad);
    end
    drive_write(3'd7, 2'b01, 2'b00);
    tick();
    idle_write();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_sweep(busy_cycles, got_done);
    checks++;
    if (busy_cycles != 8 || got_done !== 1'b1 || rd_data !== 2'b00 || set_count !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_sweep busy %0d done %b rd7 %b cnt %0d exp 8 1 00 0",
               busy_cycles, got_done, rd_data, set_count);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_write();
    test_same_index();
    test_flush();
    test_sweep_write();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
